// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch port, the load/store port and the shared memory.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                i_if_req;
  logic [ADDR_W-1:0]   i_if_addr;
  logic                i_if_flush;
  logic                o_if_ready;
  logic                o_if_rvalid;
  logic [DATA_W-1:0]   o_if_rdata;

  logic                i_d_req;
  logic                i_d_wen;
  logic [ADDR_W-1:0]   i_d_addr;
  logic [DATA_W-1:0]   i_d_wdata;
  logic [DATA_W/8-1:0] i_d_mask;
  logic                o_d_ready;
  logic                o_d_rvalid;
  logic [DATA_W-1:0]   o_d_rdata;

  logic                o_mem_req;
  logic                o_mem_wen;
  logic [ADDR_W-1:0]   o_mem_addr;
  logic [DATA_W-1:0]   o_mem_wdata;
  logic [DATA_W/8-1:0] o_mem_mask;
  logic                i_mem_ready;
  logic                i_mem_rvalid;
  logic [DATA_W-1:0]   i_mem_rdata;

  modport master (
    input  i_if_req, i_if_addr, i_if_flush,
    output o_if_ready, o_if_rvalid, o_if_rdata,
    input  i_d_req, i_d_wen, i_d_addr, i_d_wdata, i_d_mask,
    output o_d_ready, o_d_rvalid, o_d_rdata,
    output o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask,
    input  i_mem_ready, i_mem_rvalid, i_mem_rdata
  );

  modport slave (
    output i_if_req, i_if_addr, i_if_flush,
    input  o_if_ready, o_if_rvalid, o_if_rdata,
    output i_d_req, i_d_wen, i_d_addr, i_d_wdata, i_d_mask,
    input  o_d_ready, o_d_rvalid, o_d_rdata,
    input  o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask,
    output i_mem_ready, i_mem_rvalid, i_mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction fetch
// and load/store, one transaction outstanding, with flush-killed fetch responses.
//
// state   | meaning
// IDLE    | no transaction outstanding, arbitrating and driving the winner to memory
// BUSY_IF | fetch accepted by memory, waiting for its response
// BUSY_D  | load/store accepted by memory, waiting for its response
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  mem_arbiter_if.master bus
);
  localparam int MASK_W = DATA_W / 8;
  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_D  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   drop;
  logic   if_elig;
  logic   win_if;
  logic   win_d;
  logic   mem_req;
  logic   hs;

  // A fetch being redirected this very cycle is not worth starting.
  assign if_elig = bus.i_if_req & ~bus.i_if_flush;
  assign win_d   = (state == IDLE) & bus.i_d_req & (~if_elig | (last_grant == GRANT_IF));
  assign win_if  = (state == IDLE) & if_elig & (~bus.i_d_req | (last_grant == GRANT_D));
  assign mem_req = i_rst_n & (win_if | win_d);
  assign hs      = mem_req & bus.i_mem_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      last_grant <= GRANT_IF;
      drop       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        last_grant <= win_d;
        drop       <= 1'b0;
      end else if ((state == BUSY_IF) && bus.i_if_flush) begin
        drop <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = win_d ? BUSY_D : BUSY_IF;
      BUSY_IF: if (bus.i_mem_rvalid) state_nxt = IDLE;
      BUSY_D:  if (bus.i_mem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.o_mem_req   = 1'b0;
    bus.o_mem_wen   = 1'b0;
    bus.o_mem_addr  = {ADDR_W{1'b0}};
    bus.o_mem_wdata = {DATA_W{1'b0}};
    bus.o_mem_mask  = {MASK_W{1'b0}};
    bus.o_if_ready  = 1'b0;
    bus.o_d_ready   = 1'b0;
    bus.o_if_rvalid = 1'b0;
    bus.o_d_rvalid  = 1'b0;
    bus.o_if_rdata  = {DATA_W{1'b0}};
    bus.o_d_rdata   = {DATA_W{1'b0}};
    if (i_rst_n) begin
      bus.o_mem_req  = mem_req;
      bus.o_if_ready = win_if & bus.i_mem_ready;
      bus.o_d_ready  = win_d & bus.i_mem_ready;
      if (win_d) begin
        bus.o_mem_wen   = bus.i_d_wen;
        bus.o_mem_addr  = bus.i_d_addr;
        bus.o_mem_wdata = bus.i_d_wdata;
        bus.o_mem_mask  = bus.i_d_mask;
      end else if (win_if) begin
        bus.o_mem_addr = bus.i_if_addr;
      end
      // A flush arriving with the response still kills it, hence the live flush term.
      bus.o_if_rvalid = (state == BUSY_IF) & bus.i_mem_rvalid & ~drop & ~bus.i_if_flush;
      bus.o_d_rvalid  = (state == BUSY_D) & bus.i_mem_rvalid;
      bus.o_if_rdata  = bus.i_mem_rdata;
      bus.o_d_rdata   = bus.i_mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with a response scoreboard
// that the negedge monitor drains whenever either rvalid pulses.
module tb_mem_arbiter;
  logic clk;
  logic rst_n;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
  } resp_t;

  resp_t exp_q[$];
  resp_t mon_exp;
  int    vectors;
  int    miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every rvalid pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (bus.o_if_rvalid === 1'b1 || bus.o_d_rvalid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_rvalid: got if=%b d=%b, expected no response",
                 bus.o_if_rvalid, bus.o_d_rvalid);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.o_d_rvalid !== mon_exp.is_d || bus.o_if_rvalid !== !mon_exp.is_d) begin
          miscompares++;
          $display("FAIL rvalid_owner: got if=%b d=%b, expected d=%b",
                   bus.o_if_rvalid, bus.o_d_rvalid, mon_exp.is_d);
        end else if (mon_exp.is_d && bus.o_d_rdata !== mon_exp.data) begin
          miscompares++;
          $display("FAIL d_rdata: got %h expected %h", bus.o_d_rdata, mon_exp.data);
        end else if (!mon_exp.is_d && bus.o_if_rdata !== mon_exp.data) begin
          miscompares++;
          $display("FAIL if_rdata: got %h expected %h", bus.o_if_rdata, mon_exp.data);
        end
      end
    end
  end

  task automatic clear_inputs();
    bus.i_if_req     = 1'b0;
    bus.i_if_addr    = 32'h0;
    bus.i_if_flush   = 1'b0;
    bus.i_d_req      = 1'b0;
    bus.i_d_wen      = 1'b0;
    bus.i_d_addr     = 32'h0;
    bus.i_d_wdata    = 32'h0;
    bus.i_d_mask     = 4'h0;
    bus.i_mem_ready  = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_if_req     = 1'b1;
    bus.i_if_addr    = 32'h0000_0010;
    bus.i_d_req      = 1'b1;
    bus.i_d_wen      = 1'b1;
    bus.i_d_addr     = 32'h0000_0300;
    bus.i_d_wdata    = 32'hFFFF_FFFF;
    bus.i_d_mask     = 4'hF;
    bus.i_mem_ready  = 1'b1;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h5555_AAAA;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.o_mem_req !== 1'b0 || bus.o_if_ready !== 1'b0 || bus.o_d_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_strobes: got req=%b if_ready=%b d_ready=%b, expected 0",
                 bus.o_mem_req, bus.o_if_ready, bus.o_d_ready);
      end
      vectors++;
      if (bus.o_mem_addr !== 32'h0 || bus.o_mem_wdata !== 32'h0 || bus.o_mem_mask !== 4'h0
          || bus.o_mem_wen !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_fields: got addr=%h wdata=%h mask=%h wen=%b, expected 0",
                 bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_mask, bus.o_mem_wen);
      end
      next_cycle();
    end
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_contention();
    logic resp_due;
    logic resp_owner;
    logic next_is_d;
    logic exp_req;
    resp_due  = 1'b0;
    resp_owner = 1'b0;
    next_is_d = 1'b1;
    bus.i_if_req    = 1'b1;
    bus.i_if_addr   = 32'h0000_0080;
    bus.i_d_req     = 1'b1;
    bus.i_d_wen     = 1'b1;
    bus.i_d_addr    = 32'h0000_0200;
    bus.i_d_wdata   = 32'h1234_5678;
    bus.i_d_mask    = 4'b0011;
    bus.i_mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.i_mem_rvalid = resp_due;
      bus.i_mem_rdata  = 32'hA000_0000 + 32'(i);
      if (resp_due) exp_q.push_back({resp_owner, 32'hA000_0000 + 32'(i)});
      exp_req = (i % 2 == 0);
      @(negedge clk);
      vectors++;
      if (bus.o_mem_req !== exp_req) begin
        miscompares++;
        $display("FAIL contention_req cycle %0d: got %b expected %b", i, bus.o_mem_req, exp_req);
      end
      if (exp_req) begin
        vectors++;
        if (bus.o_d_ready !== next_is_d || bus.o_if_ready !== !next_is_d) begin
          miscompares++;
          $display("FAIL contention_grant cycle %0d: got d_ready=%b if_ready=%b, expected d=%b",
                   i, bus.o_d_ready, bus.o_if_ready, next_is_d);
        end
        vectors++;
        if (next_is_d && (bus.o_mem_addr !== 32'h200 || bus.o_mem_wdata !== 32'h1234_5678
            || bus.o_mem_mask !== 4'b0011 || bus.o_mem_wen !== 1'b1)) begin
          miscompares++;
          $display("FAIL contention_store cycle %0d: got addr=%h wdata=%h mask=%b wen=%b",
                   i, bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_mask, bus.o_mem_wen);
        end else if (!next_is_d && (bus.o_mem_addr !== 32'h80 || bus.o_mem_wdata !== 32'h0
            || bus.o_mem_mask !== 4'h0 || bus.o_mem_wen !== 1'b0)) begin
          miscompares++;
          $display("FAIL contention_fetch cycle %0d: got addr=%h wdata=%h mask=%b wen=%b",
                   i, bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_mask, bus.o_mem_wen);
        end
        resp_due   = 1'b1;
        resp_owner = next_is_d;
        next_is_d  = !next_is_d;
      end else begin
        resp_due = 1'b0;
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_single_load();
    bus.i_d_req     = 1'b1;
    bus.i_d_wen     = 1'b0;
    bus.i_d_addr    = 32'h0000_0100;
    bus.i_mem_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.o_d_ready !== 1'b1 || bus.o_mem_req !== 1'b1 || bus.o_mem_wen !== 1'b0
        || bus.o_mem_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL load_issue: got ready=%b req=%b wen=%b addr=%h, expected 1 1 0 100",
               bus.o_d_ready, bus.o_mem_req, bus.o_mem_wen, bus.o_mem_addr);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    vectors++;
    if (bus.o_mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL load_busy_req: got %b expected 0", bus.o_mem_req);
    end
    next_cycle();
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'hDEAD_BEEF;
    exp_q.push_back({1'b1, 32'hDEAD_BEEF});
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_backpressure();
    bus.i_if_req    = 1'b1;
    bus.i_if_addr   = 32'h0000_0040;
    bus.i_mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.i_mem_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 32'h40
          || bus.o_if_ready !== bus.i_mem_ready) begin
        miscompares++;
        $display("FAIL backpressure cycle %0d: got req=%b addr=%h ready=%b, expected 1 40 %b",
                 i, bus.o_mem_req, bus.o_mem_addr, bus.o_if_ready, bus.i_mem_ready);
      end
      next_cycle();
    end
    clear_inputs();
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h0BAD_F00D;
    exp_q.push_back({1'b0, 32'h0BAD_F00D});
    next_cycle();
    clear_inputs();
  endtask

  task automatic issue_fetch(input logic [31:0] addr);
    bus.i_if_req    = 1'b1;
    bus.i_if_addr   = addr;
    bus.i_mem_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.o_if_ready !== 1'b1 || bus.o_mem_addr !== addr) begin
      miscompares++;
      $display("FAIL fetch_issue: got ready=%b addr=%h, expected 1 %h",
               bus.o_if_ready, bus.o_mem_addr, addr);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_flush();
    bus.i_if_req    = 1'b1;
    bus.i_if_addr   = 32'h0000_0044;
    bus.i_if_flush  = 1'b1;
    bus.i_mem_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.o_mem_req !== 1'b0 || bus.o_if_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ineligible: got req=%b ready=%b, expected 0 0",
               bus.o_mem_req, bus.o_if_ready);
    end
    next_cycle();
    clear_inputs();
    issue_fetch(32'h0000_0044);
    bus.i_if_flush = 1'b1;
    next_cycle();
    bus.i_if_flush = 1'b0;
    next_cycle();
    next_cycle();
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h1111_1111;
    next_cycle();
    clear_inputs();
    issue_fetch(32'h0000_0048);
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h2222_2222;
    exp_q.push_back({1'b0, 32'h2222_2222});
    next_cycle();
    clear_inputs();
    issue_fetch(32'h0000_004C);
    bus.i_mem_rvalid = 1'b1;
    bus.i_if_flush   = 1'b1;
    bus.i_mem_rdata  = 32'h3333_3333;
    next_cycle();
    clear_inputs();
    issue_fetch(32'h0000_0050);
    next_cycle();
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h4444_4444;
    exp_q.push_back({1'b0, 32'h4444_4444});
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    bus.i_d_req     = 1'b1;
    bus.i_d_wen     = 1'b1;
    bus.i_d_addr    = 32'h0000_0210;
    bus.i_d_wdata   = 32'hCAFE_0001;
    bus.i_d_mask    = 4'hF;
    bus.i_mem_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.o_d_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_issue: got d_ready=%b expected 1", bus.o_d_ready);
    end
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.o_mem_req !== 1'b0 || bus.o_d_ready !== 1'b0 || bus.o_d_rvalid !== 1'b0
        || bus.o_if_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_strobes: got req=%b d_ready=%b d_rv=%b if_rv=%b, expected 0",
               bus.o_mem_req, bus.o_d_ready, bus.o_d_rvalid, bus.o_if_rvalid);
    end
    next_cycle();
    rst_n = 1'b1;
    clear_inputs();
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h7777_7777;
    @(negedge clk);
    vectors++;
    if (bus.o_d_rvalid !== 1'b0 || bus.o_if_rvalid !== 1'b0 || bus.o_mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL stray_rvalid: got d_rv=%b if_rv=%b req=%b, expected 0",
               bus.o_d_rvalid, bus.o_if_rvalid, bus.o_mem_req);
    end
    next_cycle();
    clear_inputs();
    bus.i_if_req    = 1'b1;
    bus.i_if_addr   = 32'h0000_0060;
    bus.i_d_req     = 1'b1;
    bus.i_d_addr    = 32'h0000_0220;
    bus.i_mem_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.o_d_ready !== 1'b1 || bus.o_if_ready !== 1'b0 || bus.o_mem_addr !== 32'h220) begin
      miscompares++;
      $display("FAIL midrst_tie: got d_ready=%b if_ready=%b addr=%h, expected 1 0 220",
               bus.o_d_ready, bus.o_if_ready, bus.o_mem_addr);
    end
    next_cycle();
    clear_inputs();
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h8888_8888;
    exp_q.push_back({1'b1, 32'h8888_8888});
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    clear_inputs();
    test_reset();
    test_contention();
    test_single_load();
    test_backpressure();
    test_flush();
    test_reset_mid();
    next_cycle();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_responses: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
